// File: rtl/svm_pkg.sv
// Fixed-point format constants and helpers shared by the SVM pipeline blocks.
package svm_pkg;

    localparam int unsigned FRAC_BITS = 8;
    localparam int unsigned WORD_W    = 2 * FRAC_BITS;
    localparam int unsigned SCORE_W   = 24;
    localparam int unsigned WIDE_W    = 64;

    // Sign-magnitude to two's complement; negative zero maps to 0.
    function automatic logic signed [WIDE_W-1:0] sm_to_tc(input logic sgn,
                                                          input logic [WIDE_W-2:0] mag);
        logic signed [WIDE_W-1:0] pos;
        pos = $signed({1'b0, mag});
        return sgn ? -pos : pos;
    endfunction

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [WIDE_W-1:0] sat_signed(input logic signed [WIDE_W-1:0] x,
                                                            input int unsigned w);
        logic signed [WIDE_W-1:0] hi;
        logic signed [WIDE_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (x > hi) begin
            return hi;
        end
        if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/sm_mac.sv
// Sign-magnitude multiply-accumulate with synchronous clear.
module sm_mac
    import svm_pkg::*;
#(
    parameter int unsigned DATA_W = WORD_W,
    parameter int unsigned ACC_W  = 36
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic [DATA_W-1:0]       a,
    input  logic [DATA_W-1:0]       b,
    output logic signed [ACC_W-1:0] acc
);

    localparam int unsigned MAG_W  = DATA_W - 1;
    localparam int unsigned PROD_W = 2 * MAG_W;

    logic [PROD_W-1:0]        prod_mag;
    logic signed [WIDE_W-1:0] prod_tc;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  acc_q;

    // Product magnitude, signed product and next accumulator value.
    always_comb begin
        prod_mag = PROD_W'(a[MAG_W-1:0]) * PROD_W'(b[MAG_W-1:0]);
        prod_tc  = sm_to_tc(a[DATA_W-1] ^ b[DATA_W-1], (WIDE_W-1)'(prod_mag));
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod_tc);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/decision_funct_mc.sv
// Multi-class one-vs-rest SVM decision stage: per-class score, sign, argmax and margin flag.
module decision_funct_mc
    import svm_pkg::*;
#(
    parameter int unsigned XLEN_PIXEL          = FRAC_BITS,
    parameter int unsigned NUM_OF_SV           = 10,
    parameter int unsigned NUM_CLASSES         = 2,
    parameter int unsigned DECISION_FUNCT_SIZE = SCORE_W,
    parameter int unsigned ADDR_W              = $clog2(NUM_CLASSES * (NUM_OF_SV + 1))
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    input  logic [2*XLEN_PIXEL*NUM_OF_SV-1:0]      kernel_out,
    output logic                                   coef_rd_en,
    output logic [ADDR_W-1:0]                      coef_addr,
    input  logic [2*XLEN_PIXEL-1:0]                coef_data,
    input  logic [DECISION_FUNCT_SIZE-2:0]         margin_thr,
    output logic                                   busy,
    output logic                                   done,
    output logic [NUM_CLASSES-1:0]                 y_class,
    output logic [((NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1)-1:0] class_idx,
    output logic [DECISION_FUNCT_SIZE-1:0]         best_score,
    output logic                                   margin_ok
);

    localparam int unsigned DW     = 2 * XLEN_PIXEL;
    localparam int unsigned KW     = DW * NUM_OF_SV;
    localparam int unsigned SW     = DECISION_FUNCT_SIZE;
    localparam int unsigned ACC_W  = 2 * (DW - 1) + $clog2(NUM_OF_SV) + 2;
    localparam int unsigned IDX_W  = $clog2(NUM_OF_SV + 1);
    localparam int unsigned CIDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MAC  = 3'd1;
    localparam logic [2:0] S_BIAS = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]              state_q, state_d;
    logic [IDX_W-1:0]        i_q, i_d;
    logic [CIDX_W-1:0]       c_q, c_d;
    logic [KW-1:0]           kernel_q, kernel_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [NUM_CLASSES-1:0]  y_q, y_d;
    logic [CIDX_W-1:0]       idx_q, idx_d;
    logic signed [SW-1:0]    best_q, best_d;
    logic                    mok_q, mok_d;

    logic                    mac_clr;
    logic                    mac_en;
    logic [IDX_W-1:0]        k_idx;
    logic [DW-1:0]           kernel_word;
    logic signed [ACC_W-1:0] acc;
    logic signed [WIDE_W-1:0] bias_tc;
    logic signed [WIDE_W-1:0] sum_w;
    logic signed [SW-1:0]    score_fin;
    logic [SW-2:0]           best_abs;

    // Kernel value paired with the coefficient arriving this cycle (address i-1).
    always_comb begin
        k_idx       = i_q - IDX_W'(1);
        kernel_word = kernel_q[32'(k_idx) * DW +: DW];
    end

    sm_mac #(
        .DATA_W (DW),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (kernel_word),
        .b     (coef_data),
        .acc   (acc)
    );

    // Add bias aligned to the product format, floor back to score format and saturate.
    always_comb begin
        bias_tc   = sm_to_tc(coef_data[DW-1], (WIDE_W-1)'(coef_data[DW-2:0]));
        sum_w     = WIDE_W'(acc) + (bias_tc <<< XLEN_PIXEL);
        score_fin = SW'(sat_signed(sum_w >>> XLEN_PIXEL, SW));
        if (best_q == {1'b1, {(SW-1){1'b0}}}) begin
            best_abs = {(SW-1){1'b1}};
        end else if (best_q[SW-1]) begin
            best_abs = (SW-1)'(-best_q);
        end else begin
            best_abs = (SW-1)'(best_q);
        end
    end

    // Next-state, counters, ROM addressing and result updates.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        c_d      = c_q;
        kernel_d = kernel_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        y_d      = y_q;
        idx_d    = idx_q;
        best_d   = best_q;
        mok_d    = mok_q;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    kernel_d = kernel_out;
                    c_d      = '0;
                    i_d      = '0;
                    mac_clr  = 1'b1;
                    busy_d   = 1'b1;
                    y_d      = '0;
                    idx_d    = '0;
                    best_d   = '0;
                    mok_d    = 1'b0;
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                mac_en = (i_q != '0);
                if (i_q == IDX_W'(NUM_OF_SV - 1)) begin
                    i_d     = IDX_W'(NUM_OF_SV);
                    state_d = S_BIAS;
                end else begin
                    i_d = i_q + IDX_W'(1);
                end
            end
            S_BIAS: begin
                mac_en  = 1'b1;
                state_d = S_FIN;
            end
            S_FIN: begin
                y_d[c_q] = score_fin[SW-1];
                if ((c_q == '0) || (score_fin > best_q)) begin
                    best_d = score_fin;
                    idx_d  = c_q;
                end
                if (c_q == CIDX_W'(NUM_CLASSES - 1)) begin
                    state_d = S_DONE;
                end else begin
                    c_d     = c_q + CIDX_W'(1);
                    i_d     = '0;
                    mac_clr = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                mok_d   = (best_abs >= margin_thr);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_en_d = (state_d == S_MAC) || (state_d == S_BIAS);
        addr_d  = rd_en_d ? ADDR_W'(32'(c_d) * (NUM_OF_SV + 1) + 32'(i_d)) : '0;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            c_q      <= '0;
            kernel_q <= '0;
            rd_en_q  <= 1'b0;
            addr_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            y_q      <= '0;
            idx_q    <= '0;
            best_q   <= '0;
            mok_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            c_q      <= c_d;
            kernel_q <= kernel_d;
            rd_en_q  <= rd_en_d;
            addr_q   <= addr_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            y_q      <= y_d;
            idx_q    <= idx_d;
            best_q   <= best_d;
            mok_q    <= mok_d;
        end
    end

    assign coef_rd_en = rd_en_q;
    assign coef_addr  = addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign y_class    = y_q;
    assign class_idx  = idx_q;
    assign best_score = best_q;
    assign margin_ok  = mok_q;

endmodule

// File: tb/tb_decision_funct_mc.sv
// Directed bench for decision_funct_mc: small (2 SV x 2 classes) and default instances.
module tb_decision_funct_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    // Small instance: NUM_OF_SV=2, NUM_CLASSES=2
    logic        start_s;
    logic [31:0] kern_s;
    logic        rd_s;
    logic [2:0]  addr_s;
    logic [15:0] data_s;
    logic [22:0] thr_s;
    logic        busy_s, done_s, mok_s;
    logic [1:0]  y_s;
    logic [0:0]  idx_s;
    logic [23:0] best_s;
    logic [15:0] rom_s [0:7];

    // Default instance: NUM_OF_SV=10, NUM_CLASSES=2
    logic         start_d;
    logic [159:0] kern_d;
    logic         rd_d;
    logic [4:0]   addr_d;
    logic [15:0]  data_d;
    logic [22:0]  thr_d;
    logic         busy_d, done_d, mok_d;
    logic [1:0]   y_d;
    logic [0:0]   idx_d;
    logic [23:0]  best_d;
    logic [15:0]  rom_d [0:31];

    decision_funct_mc #(
        .XLEN_PIXEL(8), .NUM_OF_SV(2), .NUM_CLASSES(2), .DECISION_FUNCT_SIZE(24)
    ) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .kernel_out(kern_s),
        .coef_rd_en(rd_s), .coef_addr(addr_s), .coef_data(data_s), .margin_thr(thr_s),
        .busy(busy_s), .done(done_s), .y_class(y_s), .class_idx(idx_s),
        .best_score(best_s), .margin_ok(mok_s)
    );

    decision_funct_mc dut_d (
        .clk(clk), .rst_n(rst_n), .start(start_d), .kernel_out(kern_d),
        .coef_rd_en(rd_d), .coef_addr(addr_d), .coef_data(data_d), .margin_thr(thr_d),
        .busy(busy_d), .done(done_d), .y_class(y_d), .class_idx(idx_d),
        .best_score(best_d), .margin_ok(mok_d)
    );

    // Coefficient ROM models with one-cycle read latency.
    always @(posedge clk) begin
        if (rd_s) data_s <= rom_s[addr_s];
        if (rd_d) data_d <= rom_d[addr_d];
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic load_s(input logic [15:0] c0a, input logic [15:0] c0b, input logic [15:0] b0,
                          input logic [15:0] c1a, input logic [15:0] c1b, input logic [15:0] b1);
        rom_s[0] = c0a; rom_s[1] = c0b; rom_s[2] = b0;
        rom_s[3] = c1a; rom_s[4] = c1b; rom_s[5] = b1;
        rom_s[6] = 16'h0; rom_s[7] = 16'h0;
    endtask

    task automatic load_d(input logic [15:0] coef, input logic [15:0] bias);
        for (int k = 0; k < 32; k++) rom_d[k] = coef;
        rom_d[10] = bias;
        rom_d[21] = bias;
    endtask

    // Pulse start; return number of edges after the accept edge until done is seen.
    task automatic run_s(output int lat);
        lat = -1;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        for (int n = 0; n <= 60; n++) begin
            @(negedge clk);
            if (done_s) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_d(output int lat);
        lat = -1;
        @(posedge clk); #1 start_d = 1'b1;
        @(posedge clk); #1 start_d = 1'b0;
        for (int n = 0; n <= 80; n++) begin
            @(negedge clk);
            if (done_d) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({busy_s, done_s, rd_s, mok_s} !== 4'b0) begin failures++;
            $display("FAIL reset_s_ctrl got=%b exp=0000", {busy_s, done_s, rd_s, mok_s}); end
        checks++; if ({y_s, idx_s, best_s} !== 27'h0) begin failures++;
            $display("FAIL reset_s_result got=%h exp=0", {y_s, idx_s, best_s}); end
        checks++; if ({busy_d, done_d, rd_d, mok_d} !== 4'b0) begin failures++;
            $display("FAIL reset_d_ctrl got=%b exp=0000", {busy_d, done_d, rd_d, mok_d}); end
        checks++; if ({y_d, idx_d, best_d} !== 27'h0) begin failures++;
            $display("FAIL reset_d_result got=%h exp=0", {y_d, idx_d, best_d}); end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        load_s(16'h0080, 16'h8100, 16'h0040, 16'h0100, 16'h0100, 16'h8100);
        kern_s = {16'h0200, 16'h0100};
        thr_s  = 23'h000200;
        run_s(lat);
        checks++; if (lat !== 9) begin failures++;
            $display("FAIL basic_latency got=%0d exp=9", lat); end
        checks++; if (y_s !== 2'b01) begin failures++;
            $display("FAIL basic_y_class got=%b exp=01", y_s); end
        checks++; if (idx_s !== 1'b1) begin failures++;
            $display("FAIL basic_class_idx got=%0d exp=1", idx_s); end
        checks++; if (best_s !== 24'h000200) begin failures++;
            $display("FAIL basic_best_score got=%h exp=000200", best_s); end
        checks++; if (mok_s !== 1'b1) begin failures++;
            $display("FAIL basic_margin_eq got=%b exp=1", mok_s); end
        checks++; if (busy_s !== 1'b0) begin failures++;
            $display("FAIL basic_busy_at_done got=%b exp=0", busy_s); end
        @(negedge clk);
        checks++; if (done_s !== 1'b0) begin failures++;
            $display("FAIL basic_done_pulse got=%b exp=0", done_s); end

        thr_s = 23'h000201;
        run_s(lat);
        checks++; if (mok_s !== 1'b0) begin failures++;
            $display("FAIL basic_margin_above got=%b exp=0", mok_s); end
        checks++; if (best_s !== 24'h000200) begin failures++;
            $display("FAIL basic_best_rerun got=%h exp=000200", best_s); end

        // Class 1 at -3.0 leaves class 0 (-1.25) as the argmax.
        load_s(16'h0080, 16'h8100, 16'h0040, 16'h8100, 16'h8100, 16'h0000);
        thr_s = 23'h000100;
        run_s(lat);
        checks++; if (best_s !== 24'hFFFEC0) begin failures++;
            $display("FAIL neg_best_score got=%h exp=fffec0", best_s); end
        checks++; if ({y_s, idx_s} !== 3'b110) begin failures++;
            $display("FAIL neg_y_idx got=%b exp=110", {y_s, idx_s}); end
        checks++; if (mok_s !== 1'b1) begin failures++;
            $display("FAIL neg_margin got=%b exp=1", mok_s); end
    endtask

    task automatic test_saturation();
        int lat;
        kern_d = {10{16'h7FFF}};
        thr_d  = 23'h7FFFFF;
        load_d(16'h7FFF, 16'h0000);
        run_d(lat);
        checks++; if (lat !== 25) begin failures++;
            $display("FAIL sat_latency got=%0d exp=25", lat); end
        checks++; if (best_d !== 24'h7FFFFF) begin failures++;
            $display("FAIL sat_pos_best got=%h exp=7fffff", best_d); end
        checks++; if ({y_d, idx_d, mok_d} !== 4'b0001) begin failures++;
            $display("FAIL sat_pos_y_idx_margin got=%b exp=0001", {y_d, idx_d, mok_d}); end

        load_d(16'hFFFF, 16'hFFFF);
        run_d(lat);
        checks++; if (best_d !== 24'h800000) begin failures++;
            $display("FAIL sat_neg_best got=%h exp=800000", best_d); end
        checks++; if ({y_d, idx_d} !== 3'b110) begin failures++;
            $display("FAIL sat_neg_y_idx got=%b exp=110", {y_d, idx_d}); end
        checks++; if (mok_d !== 1'b1) begin failures++;
            $display("FAIL sat_neg_margin got=%b exp=1", mok_d); end
    endtask

    task automatic test_neg_zero_tie();
        int lat;
        load_s(16'h0080, 16'h8100, 16'h0040, 16'h8100, 16'h8100, 16'h0000);
        kern_s = {16'h8000, 16'h8000};
        load_s(16'h0100, 16'h0100, 16'h8000, 16'h0100, 16'h0100, 16'h8000);
        thr_s  = 23'h000001;
        run_s(lat);
        checks++; if (best_s !== 24'h000000) begin failures++;
            $display("FAIL negzero_best got=%h exp=000000", best_s); end
        checks++; if ({y_s, idx_s, mok_s} !== 4'b0000) begin failures++;
            $display("FAIL negzero_y_idx_margin got=%b exp=0000", {y_s, idx_s, mok_s}); end

        kern_s = {16'h0100, 16'h0100};
        load_s(16'h0100, 16'h0100, 16'h0000, 16'h0100, 16'h0100, 16'h0000);
        run_s(lat);
        checks++; if (best_s !== 24'h000200) begin failures++;
            $display("FAIL tie_best got=%h exp=000200", best_s); end
        checks++; if ({y_s, idx_s} !== 3'b000) begin failures++;
            $display("FAIL tie_y_idx got=%b exp=000", {y_s, idx_s}); end
    endtask

    task automatic test_addr_seq(input bit hold);
        logic       exp_rd;
        logic [4:0] exp_addr;
        @(posedge clk); #1 start_d = 1'b1;
        @(posedge clk); #1 if (!hold) start_d = 1'b0;
        for (int e = 0; e <= 24; e++) begin
            @(negedge clk);
            exp_rd   = !((e == 11) || (e >= 23));
            exp_addr = (e <= 10) ? 5'(e) : 5'(e - 1);
            checks++;
            if ((rd_d !== exp_rd) || (exp_rd && (addr_d !== exp_addr))) begin failures++;
                $display("FAIL addr_seq hold=%0d cycle=%0d got rd=%b addr=%0d exp rd=%b addr=%0d",
                         hold, e, rd_d, addr_d, exp_rd, exp_addr); end
        end
        @(negedge clk);
        checks++; if ({done_d, busy_d} !== 2'b10) begin failures++;
            $display("FAIL addr_seq_done hold=%0d got done,busy=%b exp=10", hold, {done_d, busy_d}); end
        start_d = 1'b0;
        @(negedge clk);
        checks++; if ({busy_d, rd_d} !== 2'b00) begin failures++;
            $display("FAIL addr_seq_idle hold=%0d got busy,rd=%b exp=00", hold, {busy_d, rd_d}); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        int bad;
        pulses = 0;
        bad    = 0;
        load_s(16'h0080, 16'h8100, 16'h0040, 16'h0100, 16'h0100, 16'h8100);
        kern_s = {16'h0200, 16'h0100};
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done_s) begin
                pulses++;
                if ((n % 10 != 9) || (y_s !== 2'b01) || (best_s !== 24'h000200)) bad++;
            end
        end
        start_s = 1'b0;
        checks++; if (pulses !== 4) begin failures++;
            $display("FAIL b2b_pulse_count got=%0d exp=4", pulses); end
        checks++; if (bad !== 0) begin failures++;
            $display("FAIL b2b_pulse_timing_or_result got=%0d bad pulses exp=0", bad); end
        @(negedge clk);
        checks++; if (busy_s !== 1'b0) begin failures++;
            $display("FAIL b2b_idle_after got=%b exp=0", busy_s); end
    endtask

    task automatic test_reset_mid();
        int lat;
        load_s(16'h0080, 16'h8100, 16'h0040, 16'h0100, 16'h0100, 16'h8100);
        kern_s = {16'h0200, 16'h0100};
        thr_s  = 23'h000200;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++; if ({busy_s, rd_s, addr_s, y_s} !== 7'b1101101) begin failures++;
            $display("FAIL midrst_pre got busy,rd,addr,y=%b exp=1101101", {busy_s, rd_s, addr_s, y_s}); end
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({busy_s, done_s, rd_s, mok_s} !== 4'b0) begin failures++;
            $display("FAIL midrst_ctrl got=%b exp=0000", {busy_s, done_s, rd_s, mok_s}); end
        checks++; if ({y_s, idx_s, best_s} !== 27'h0) begin failures++;
            $display("FAIL midrst_result got=%h exp=0", {y_s, idx_s, best_s}); end
        @(negedge clk);
        checks++; if ({busy_s, rd_s} !== 2'b00) begin failures++;
            $display("FAIL midrst_stays_idle got=%b exp=00", {busy_s, rd_s}); end
        run_s(lat);
        checks++; if (lat !== 9) begin failures++;
            $display("FAIL midrst_rerun_latency got=%0d exp=9", lat); end
        checks++; if ({y_s, idx_s, best_s, mok_s} !== {2'b01, 1'b1, 24'h000200, 1'b1}) begin failures++;
            $display("FAIL midrst_rerun_result got=%h exp=%h", {y_s, idx_s, best_s, mok_s},
                     {2'b01, 1'b1, 24'h000200, 1'b1}); end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_s = 1'b0;
        start_d = 1'b0;
        kern_s  = '0;
        kern_d  = '0;
        thr_s   = '0;
        thr_d   = '0;
        load_s(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        load_d(16'h0, 16'h0);

        test_reset();
        test_basic();
        test_saturation();
        test_neg_zero_tie();
        test_addr_seq(1'b0);
        test_addr_seq(1'b1);
        test_back_to_back();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decision_funct_mc.md
Name: decision_funct_mc

Overview:
- Multi-class successor of the single-class SVM decision stage. Computes score_c = sum_i(kernel_i * coef_c,i) + b_c for each of NUM_CLASSES one-vs-rest classifiers.
- Reads per-class coefficients and biases from an external coefficient ROM through a 1-cycle-latency read port.
- Reports a sign bit per class, the argmax class with its score, and a cascade margin flag so the next cascade stage can decide whether to re-classify.
- Sits between the kernel block and the cascade controller.

Parameters:
- XLEN_PIXEL, 8: half-width of the fixed-point word. Data words are 2*XLEN_PIXEL wide, sign-magnitude, Q(XLEN_PIXEL-1).XLEN_PIXEL.
- NUM_OF_SV, 10: support vectors per class.
- NUM_CLASSES, 2: number of one-vs-rest classifiers (≥1).
- DECISION_FUNCT_SIZE, 24: score width, two's complement, XLEN_PIXEL fractional bits.
- ADDR_W, $clog2(NUM_CLASSES*(NUM_OF_SV+1)): ROM address width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request pulse; accepted only in IDLE.
- kernel_out  in  2*XLEN_PIXEL*NUM_OF_SV  packed kernel values, SV i at [2*i*XLEN_PIXEL +: 2*XLEN_PIXEL], sign-magnitude; sampled on the start-accept cycle.
- coef_rd_en  out  1  ROM read strobe.
- coef_addr  out  ADDR_W  = c*(NUM_OF_SV+1)+i; index NUM_OF_SV holds b_c.
- coef_data  in  2*XLEN_PIXEL  ROM data, sign-magnitude, valid the cycle after coef_rd_en.
- margin_thr  in  DECISION_FUNCT_SIZE-1  unsigned magnitude threshold, same format as score.
- busy  out  1  high from start-accept until done.
- done  out  1  one-cycle pulse; result outputs valid from done onward until the next accept.
- y_class  out  NUM_CLASSES  bit c = sign of score_c (1 = negative).
- class_idx  out  $clog2(NUM_CLASSES) (min 1)  argmax class.
- best_score  out  DECISION_FUNCT_SIZE  score of class_idx.
- margin_ok  out  1  |best_score| >= margin_thr.

Behaviour:
- States: IDLE, MAC, BIAS, FIN, DONE.
- Reset (any state, mid-run included): state IDLE, counters 0, accumulator 0. Outputs busy, done, coef_rd_en, y_class, class_idx, best_score, margin_ok all 0. No ROM read may remain pending.
- IDLE: start=1 → latch kernel_out, c=0, i=0, clear accumulator, busy=1 → MAC. start while not IDLE is ignored.
- MAC: each cycle coef_rd_en=1 with coef_addr=(c,i). The coefficient returned for address i-1 is multiplied and accumulated. After i=NUM_OF_SV-1 → BIAS.
- BIAS: read address (c,NUM_OF_SV); accumulate last SV product → FIN.
- FIN: coef_rd_en=0; add bias; finalise score_c; update y_class[c] and argmax. If c<NUM_CLASSES-1, then c++, i=0, clear accumulator → MAC; else → DONE.
- DONE: done=1, busy=0, margin_ok registered → IDLE. A start in the DONE cycle is ignored.
- Latency: done asserts exactly 1+NUM_CLASSES*(NUM_OF_SV+2) cycles after the accept edge (defaults: 25).
- Multiply: magnitude(2*XLEN_PIXEL-1) × magnitude(2*XLEN_PIXEL-1); sign = XOR of the two signs. The product is converted to two's complement before accumulation.
- Negative zero: magnitude 0 with sign 1 contributes 0.
- Accumulator: signed, 2*(2*XLEN_PIXEL-1)+$clog2(NUM_OF_SV)+2 bits, 2*XLEN_PIXEL fractional bits. It cannot overflow.
- Bias: converted to two's complement and left-shifted XLEN_PIXEL bits before adding.
- Finalise: arithmetic right shift by XLEN_PIXEL (floor), then saturate to the signed DECISION_FUNCT_SIZE range (max 0x7FFFFF, min 0x800000 at default width).
- y_class[c] = finalised score < 0; score 0 gives 0.
- Argmax: class 0 initialises best; a later class replaces it only on strictly greater score, so ties keep the lowest index.
- |best_score|: saturate 0x800000 magnitude to 0x7FFFFF.
- Results of previous run hold until the next accept; on accept, y_class/class_idx/best_score/margin_ok clear to 0.

Decomposition:
- Shared package svm_pkg: fixed-point format constants (frac bits, word width), an sm_to_tc conversion function, and a saturate function. These are reused by the kernel and cascade blocks.
- One sub-module, sm_mac: sign-magnitude multiply, conversion, accumulate, clear. The top holds the FSM, addressing, finalise and argmax.

Test Plan:
- NUM_OF_SV=2, NUM_CLASSES=2. Kernels 0x0100, 0x0200. ROM: c0 = {0x0080, 0x8100, 0x0040}, c1 = {0x0100, 0x0100, 0x8100}. → done 9 cycles after accept; y_class=2'b01; class_idx=1; best_score=0x000200; score_0 internally 0xFFFEC0. margin_thr=0x000200 → margin_ok=1; margin_thr=0x000201 → margin_ok=0.
- Defaults, all kernels 0x7FFF, all coefs 0x7FFF, bias 0 → best_score=0x7FFFFF, y_class=0. All coefs 0xFFFF → each score=0x800000, y_class=2'b11, class_idx=0.
- Kernel 0x8000 (negative zero) against coefs 0x0100, bias 0x8000 → score 0, y_class bit 0, class_idx=0 on tie.
- Check coef_addr sequence 0,1,…,10 (class 0) then 11,…,21 (class 1), with exactly one idle cycle (rd_en=0) between classes in FIN. Repeat with a start pulse held high throughout: only one run per IDLE visit.
- rst_n=0 for one cycle during MAC of class 1 → next cycle all outputs 0 and state IDLE. A fresh start then yields results identical to an uninterrupted run.
